// File: rtl/pipe_ctl.sv
// Hazard/flush controller for the 5-stage pipeline: load-use stalls, memory-wait freezes and
// multi-cycle front-end flushes. Define PIPE_CTL_PERF_EN to add stall/flush performance counters.
module pipe_ctl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load,
    input  logic             bj_en,
    input  logic             trap_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_clear,
    output logic             idex_stall,
    output logic             idex_clear,
    output logic             exmem_stall,
    output logic             exmem_clear,
    output logic             memwb_clear,
`ifdef PIPE_CTL_PERF_EN
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        MWAIT = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);
    localparam state_t     REDIR_ST = (FLUSH_CYCLES == 0) ? RUN : FLUSH;

    if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 15 || CNT_W < 1) begin : g_bad_param
        $error("pipe_ctl: FLUSH_CYCLES must be 0..15 and CNT_W >= 1");
    end

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       memwait;
    logic       load_use;

    assign memwait  = mem_req & ~mem_ready;
    // x0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign load_use = ex_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority: trap > memory wait > redirect > flush countdown / MWAIT release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (trap_en) begin
            state_d = REDIR_ST;
            cnt_d   = FLUSH_LD;
        end else if (memwait) begin
            state_d = MWAIT;
        end else if (bj_en) begin
            state_d = REDIR_ST;
            cnt_d   = FLUSH_LD;
        end else begin
            case (state_q)
                FLUSH: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end
                end
                // A flush interrupted by a memory wait resumes with its remaining count.
                MWAIT:   state_d = (cnt_q != 4'd0) ? FLUSH : RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_clear  = 1'b0;
        idex_stall  = 1'b0;
        idex_clear  = 1'b0;
        exmem_stall = 1'b0;
        exmem_clear = 1'b0;
        memwb_clear = 1'b0;
        busy        = (state_q != RUN);
        if (!rst_n) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            exmem_clear = 1'b1;
            memwb_clear = 1'b1;
            busy        = 1'b0;
        end else if (trap_en) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            exmem_clear = 1'b1;
        end else if (memwait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_clear = 1'b1;
        end else if (bj_en) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
        end else if (state_q == FLUSH) begin
            ifid_clear  = 1'b1;
        end else if (state_q == RUN && load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_clear  = 1'b1;
        end
    end

`ifdef PIPE_CTL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             redirect;

    assign redirect = trap_en | (bj_en & ~memwait);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
        if (redirect && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Scoreboard bench for pipe_ctl: per-cycle stimulus with the expected output vector queued
// at drive time and compared just before the next rising edge.
module tb_pipe_ctl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_load = 1'b0;
    logic       bj_en = 1'b0, trap_en = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_stall, ifid_stall, ifid_clear, idex_stall, idex_clear;
    logic       exmem_stall, exmem_clear, memwb_clear, busy;

    int tests_run = 0;
    int tests_failed = 0;
    logic [8:0] exp_q[$];

    // {pc_stall, ifid_stall, ifid_clear, idex_stall, idex_clear, exmem_stall, exmem_clear, memwb_clear, busy}
    localparam logic [8:0] O_IDLE = 9'b000000000;
    localparam logic [8:0] O_RST  = 9'b001010110;
    localparam logic [8:0] O_LU   = 9'b110010000;
    localparam logic [8:0] O_BJ   = 9'b001010000;
    localparam logic [8:0] O_BJB  = 9'b001010001;
    localparam logic [8:0] O_FL   = 9'b001000001;
    localparam logic [8:0] O_MW   = 9'b110101010;
    localparam logic [8:0] O_MWB  = 9'b110101011;
    localparam logic [8:0] O_TR   = 9'b001010100;
    localparam logic [8:0] O_TRB  = 9'b001010101;
    localparam logic [8:0] O_BUSY = 9'b000000001;

    // {trap_en, bj_en, mem_req, mem_ready, ex_load, id_use_rs1, id_use_rs2}
    localparam logic [6:0] S_IDLE  = 7'b0000000;
    localparam logic [6:0] S_BJ    = 7'b0100000;
    localparam logic [6:0] S_TRAP  = 7'b1000000;
    localparam logic [6:0] S_MW    = 7'b0010000;
    localparam logic [6:0] S_MWBJ  = 7'b0110000;
    localparam logic [6:0] S_RDY   = 7'b0011000;
    localparam logic [6:0] S_RDYBJ = 7'b0111000;
    localparam logic [6:0] S_TRMW  = 7'b1110000;
    localparam logic [6:0] S_LU1   = 7'b0000110;
    localparam logic [6:0] S_LU2   = 7'b0000101;
    localparam logic [6:0] S_LDNU  = 7'b0000100;

`ifdef PIPE_CTL_PERF_EN
    logic [2:0] perf_stall_cnt, perf_flush_cnt;
    pipe_ctl #(.FLUSH_CYCLES(2), .CNT_W(3)) dut (
`else
    pipe_ctl #(.FLUSH_CYCLES(2)) dut (
`endif
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_load(ex_load), .bj_en(bj_en), .trap_en(trap_en),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_clear(ifid_clear),
        .idex_stall(idex_stall), .idex_clear(idex_clear),
        .exmem_stall(exmem_stall), .exmem_clear(exmem_clear), .memwb_clear(memwb_clear),
`ifdef PIPE_CTL_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {pc_stall, ifid_stall, ifid_clear, idex_stall, idex_clear,
                exmem_stall, exmem_clear, memwb_clear, busy};
    endfunction

    // Drives one cycle of inputs after the falling edge, queues its expectation and
    // returns 1 ns before the rising edge so the caller can sample the outputs.
    task automatic drive(input logic rst, input logic [6:0] s, input logic [14:0] regs,
                         input logic [8:0] e);
        @(negedge clk);
        rst_n = rst;
        {trap_en, bj_en, mem_req, mem_ready, ex_load, id_use_rs1, id_use_rs2} = s;
        {ex_rd, id_rs1, id_rs2} = regs;
        exp_q.push_back(e);
        #4;
    endtask

    task automatic test_reset();
        logic [8:0] got, e;
        for (int i = 0; i < 4; i++) begin
            drive((i == 3), S_IDLE, 15'd0, (i == 3) ? O_IDLE : O_RST);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL reset[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_load_use();
        logic [6:0]  st[8] = '{S_LU1, S_IDLE, S_LDNU, S_LU2, S_LU1, S_LU2, S_LU1, S_IDLE};
        logic [14:0] rg[8] = '{{5'd5, 5'd5, 5'd9}, {5'd5, 5'd5, 5'd9}, {5'd5, 5'd5, 5'd5},
                               {5'd5, 5'd3, 5'd5}, {5'd0, 5'd0, 5'd0}, {5'd0, 5'd0, 5'd0},
                               {5'd7, 5'd6, 5'd7}, {5'd0, 5'd0, 5'd0}};
        logic [8:0]  ex[8] = '{O_LU, O_IDLE, O_IDLE, O_LU, O_IDLE, O_IDLE, O_IDLE, O_IDLE};
        logic [8:0] got, e;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, st[i], rg[i], ex[i]);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    // Plain flush, load-use suppression while flushing, then a redirect restarting the count.
    task automatic test_branch();
        logic [6:0] st[14] = '{S_BJ, S_IDLE, S_IDLE, S_IDLE,
                               S_BJ, S_LU1, S_LU1, S_LU1, S_IDLE,
                               S_BJ, S_IDLE, S_BJ, S_IDLE, S_IDLE};
        logic [8:0] ex[14] = '{O_BJ, O_FL, O_FL, O_IDLE,
                               O_BJ, O_FL, O_FL, O_LU, O_IDLE,
                               O_BJ, O_FL, O_BJB, O_FL, O_FL};
        logic [8:0] got, e;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, st[i], {5'd5, 5'd5, 5'd9}, ex[i]);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL branch[%0d] got=%b exp=%b", i, got, e);
            end
        end
        drive(1'b1, S_IDLE, 15'd0, O_IDLE);
        got = outs(); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL branch_end got=%b exp=%b", got, e);
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] st[8] = '{S_MWBJ, S_MWBJ, S_MWBJ, S_MWBJ, S_RDYBJ, S_IDLE, S_IDLE, S_IDLE};
        logic [8:0] ex[8] = '{O_MW, O_MWB, O_MWB, O_MWB, O_BJB, O_FL, O_FL, O_IDLE};
        logic [8:0] got, e;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, st[i], 15'd0, ex[i]);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL mem_wait[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    // Memory wait interrupting a flush keeps the remaining count; ready in RUN is not a wait.
    task automatic test_mwait_resume();
        logic [6:0] st[8] = '{S_BJ, S_MW, S_MW, S_RDY, S_IDLE, S_IDLE, S_IDLE, S_RDY};
        logic [8:0] ex[8] = '{O_BJ, O_MWB, O_MWB, O_BUSY, O_FL, O_FL, O_IDLE, O_IDLE};
        logic [8:0] got, e;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, st[i], 15'd0, ex[i]);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL mwait_resume[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_trap();
        logic       rs[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        logic [6:0] st[10] = '{S_MW, S_TRMW, S_IDLE, S_IDLE, S_IDLE,
                               S_TRAP, S_IDLE, S_IDLE, S_IDLE, S_IDLE};
        logic [8:0] ex[10] = '{O_MW, O_TRB, O_FL, O_FL, O_IDLE,
                               O_TR, O_FL, O_RST, O_IDLE, O_IDLE};
        logic [8:0] got, e;
        for (int i = 0; i < 10; i++) begin
            drive(rs[i], st[i], 15'd0, ex[i]);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL trap[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

`ifdef PIPE_CTL_PERF_EN
    // 4 wait stalls + 1 load-use stall + branch + trap, then 4 more stalls to hit saturation (CNT_W=3).
    task automatic test_perf();
        logic       rs[17] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        logic [6:0] st[17] = '{S_IDLE, S_MW, S_MW, S_MW, S_MW, S_RDY, S_LU1, S_BJ, S_IDLE,
                               S_IDLE, S_TRAP, S_IDLE, S_IDLE, S_IDLE, S_MW, S_MW, S_MW};
        logic [8:0] ex[17] = '{O_RST, O_MW, O_MWB, O_MWB, O_MWB, O_BUSY, O_LU, O_BJ, O_FL,
                               O_FL, O_TR, O_FL, O_FL, O_IDLE, O_MW, O_MWB, O_MWB};
        logic [8:0] got, e;
        for (int i = 0; i < 17; i++) begin
            drive(rs[i], st[i], {5'd5, 5'd5, 5'd9}, ex[i]);
            got = outs(); e = exp_q.pop_front(); tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL perf_seq[%0d] got=%b exp=%b", i, got, e);
            end
            if (i == 13) begin
                tests_run++;
                if (perf_stall_cnt !== 3'd5 || perf_flush_cnt !== 3'd2) begin
                    tests_failed++;
                    $display("FAIL perf_counts got=%0d/%0d exp=5/2", perf_stall_cnt, perf_flush_cnt);
                end
            end
        end
        drive(1'b1, S_MW, 15'd0, O_MWB);
        got = outs(); e = exp_q.pop_front(); tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL perf_last got=%b exp=%b", got, e);
        end
        drive(1'b1, S_RDY, 15'd0, O_BUSY);
        got = outs(); e = exp_q.pop_front(); tests_run++;
        if (got !== e || perf_stall_cnt !== 3'd7 || perf_flush_cnt !== 3'd2) begin
            tests_failed++;
            $display("FAIL perf_sat got=%b %0d/%0d exp=%b 7/2", got, perf_stall_cnt, perf_flush_cnt, e);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_mwait_resume();
        test_trap();
`ifdef PIPE_CTL_PERF_EN
        test_perf();
`endif
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
